// File: rtl/lane_if.sv
// Lane traffic bundle: slow-rate input, game controls and car positions
// shared by the lane engine and its consumers (VGA, collision logic).
interface lane_if #(
    parameter int NUM_CARS = 3
);
    logic                     slow_clk;
    logic                     start;
    logic                     restart;
    logic                     dir;
    logic [1:0]               speed;
    logic [NUM_CARS*10-1:0]   car_x;
    logic                     step_pulse;
    logic [NUM_CARS-1:0]      wrap_pulse;
    logic                     busy;

    modport master (
        output slow_clk, start, restart, dir, speed,
        input  car_x, step_pulse, wrap_pulse, busy
    );

    modport slave (
        input  slow_clk, start, restart, dir, speed,
        output car_x, step_pulse, wrap_pulse, busy
    );
endinterface

// File: rtl/lane_traffic_ctrl.sv
// Per-lane car mover: turns rising edges of a divided clock into step events
// and advances NUM_CARS x-positions with wrap at SCREEN_W.
//
// state | meaning
// IDLE  | lane at initial positions, waiting for start
// WAIT  | start seen, swallowing START_DELAY ticks before moving
// RUN   | every tick moves all cars
// HOLD  | paused by start=0; resumes to RUN without a new delay
module lane_traffic_ctrl #(
    parameter int NUM_CARS    = 3,
    parameter int SCREEN_W    = 640,
    parameter int SPACING     = 200,
    parameter int START_DELAY = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    lane_if.slave  lane
);
    typedef enum logic [1:0] {IDLE, WAIT, RUN, HOLD} state_t;

    localparam logic [10:0] W11 = 11'(SCREEN_W);
    localparam logic [3:0]  DLY = 4'(START_DELAY);

    state_t              state, state_nxt;
    logic [3:0]          delay_cnt, delay_nxt;
    logic                slow_d;
    logic                tick;
    logic                step_nxt;
    logic                step_q;
    logic                busy_q;
    logic [NUM_CARS-1:0] wrap_q;
    logic [10:0]         spd;
    logic [9:0]          pos [NUM_CARS];
    logic [10:0]         mv  [NUM_CARS];

    function automatic logic [9:0] init_pos(input int i);
        return 10'((i * SPACING) % SCREEN_W);
    endfunction

    // Returns {wrapped, new_x}; 11-bit math keeps x+s and x+W-s exact.
    function automatic logic [10:0] move_car(input logic [9:0] x, input logic left,
                                             input logic [10:0] s);
        logic [10:0] xw;
        logic [10:0] n;
        xw = {1'b0, x};
        if (!left) begin
            n = xw + s;
            if (n >= W11) begin
                n = n - W11;
                return {1'b1, n[9:0]};
            end
            return {1'b0, n[9:0]};
        end
        if (xw < s) begin
            n = xw + W11 - s;
            return {1'b1, n[9:0]};
        end
        n = xw - s;
        return {1'b0, n[9:0]};
    endfunction

    assign tick = lane.slow_clk & ~slow_d;
    assign spd  = 11'(lane.speed) + 11'd1;

    always_comb begin
        state_nxt = state;
        delay_nxt = delay_cnt;
        step_nxt  = 1'b0;
        if (lane.restart) begin
            state_nxt = IDLE;
            delay_nxt = 4'd0;
        end else begin
            case (state)
                IDLE: if (lane.start) begin
                    if (DLY == 4'd0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = WAIT;
                        delay_nxt = DLY;
                    end
                end
                WAIT: if (!lane.start) begin
                    state_nxt = HOLD;
                end else if (tick) begin
                    delay_nxt = delay_cnt - 4'd1;
                    if (delay_cnt <= 4'd1) state_nxt = RUN;
                end
                RUN: if (!lane.start) begin
                    state_nxt = HOLD;
                end else if (tick) begin
                    step_nxt = 1'b1;
                end
                HOLD: if (lane.start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CARS; i++) mv[i] = move_car(pos[i], lane.dir, spd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            delay_cnt <= 4'd0;
            slow_d    <= 1'b0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            wrap_q    <= '0;
            for (int i = 0; i < NUM_CARS; i++) pos[i] <= init_pos(i);
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
            slow_d    <= lane.slow_clk;
            step_q    <= step_nxt;
            busy_q    <= (state_nxt == WAIT) || (state_nxt == RUN);
            for (int i = 0; i < NUM_CARS; i++) begin
                wrap_q[i] <= step_nxt & mv[i][10];
                if (lane.restart)  pos[i] <= init_pos(i);
                else if (step_nxt) pos[i] <= mv[i][9:0];
            end
        end
    end

    always_comb begin
        lane.car_x = '0;
        for (int i = 0; i < NUM_CARS; i++) lane.car_x[10*i +: 10] = pos[i];
    end

    assign lane.step_pulse = step_q;
    assign lane.wrap_pulse = wrap_q;
    assign lane.busy       = busy_q;
endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Directed and randomized checks of lane_traffic_ctrl against a cycle-level
// behavioural model using modular arithmetic on integer positions.
module tb_lane_traffic_ctrl;
    localparam int NC    = 3;
    localparam int W     = 640;
    localparam int SP    = 200;
    localparam int DELAY = 4;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_HOLD = 3;

    logic clk;
    logic rst_n;

    lane_if #(.NUM_CARS(NC)) ifc ();

    lane_traffic_ctrl #(
        .NUM_CARS(NC), .SCREEN_W(W), .SPACING(SP), .START_DELAY(DELAY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lane (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int steps_seen = 0;

    int          m_pos [NC];
    int          m_phase;
    int          m_swallow;
    bit          m_prev;
    bit          m_step;
    bit [NC-1:0] m_wrap;
    bit          m_busy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_x();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[10*i +: 10] = 10'((i * SP) % W);
        return v;
    endfunction

    function automatic logic [31:0] model_x();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[10*i +: 10] = 10'(m_pos[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_pos[i] = (i * SP) % W;
        m_phase   = M_IDLE;
        m_swallow = 0;
        m_prev    = 1'b0;
        m_step    = 1'b0;
        m_wrap    = '0;
        m_busy    = 1'b0;
    endtask

    task automatic model_update();
        bit tick;
        int s;
        tick   = ifc.slow_clk && !m_prev;
        m_prev = ifc.slow_clk;
        m_step = 1'b0;
        m_wrap = '0;
        s      = int'(ifc.speed) + 1;
        if (ifc.restart) begin
            for (int i = 0; i < NC; i++) m_pos[i] = (i * SP) % W;
            m_phase   = M_IDLE;
            m_swallow = 0;
        end else if (m_phase == M_IDLE) begin
            if (ifc.start) begin
                m_swallow = DELAY;
                m_phase   = (DELAY == 0) ? M_RUN : M_WAIT;
            end
        end else if (m_phase == M_WAIT) begin
            if (!ifc.start) m_phase = M_HOLD;
            else if (tick) begin
                m_swallow--;
                if (m_swallow == 0) m_phase = M_RUN;
            end
        end else if (m_phase == M_RUN) begin
            if (!ifc.start) m_phase = M_HOLD;
            else if (tick) begin
                m_step = 1'b1;
                for (int i = 0; i < NC; i++) begin
                    if (!ifc.dir) begin
                        m_wrap[i] = (m_pos[i] + s) >= W;
                        m_pos[i]  = (m_pos[i] + s) % W;
                    end else begin
                        m_wrap[i] = m_pos[i] < s;
                        m_pos[i]  = (m_pos[i] - s + W) % W;
                    end
                end
            end
        end else begin
            if (ifc.start) m_phase = M_RUN;
        end
        m_busy = (m_phase == M_WAIT) || (m_phase == M_RUN);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_update();
        else model_reset();
        @(negedge clk);
        if (ifc.step_pulse) steps_seen++;
        check_val("car_x", 32'(ifc.car_x), model_x());
        check_val("step_pulse", 32'(ifc.step_pulse), 32'(m_step));
        check_val("wrap_pulse", 32'(ifc.wrap_pulse), 32'(m_wrap));
        check_val("busy", 32'(ifc.busy), 32'(m_busy));
    endtask

    task automatic pulse_slow();
        ifc.slow_clk = 1'b1;
        cyc();
        ifc.slow_clk = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n       = 1'b0;
        ifc.slow_clk = 1'b0;
        ifc.start   = 1'b0;
        ifc.restart = 1'b0;
        ifc.dir     = 1'b0;
        ifc.speed   = 2'd0;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        check_val("reset_x", 32'(ifc.car_x), init_x());
        check_val("reset_busy", 32'(ifc.busy), 32'd0);

        // Idle lane: slow clock toggles but nothing moves
        steps_seen = 0;
        repeat (5) pulse_slow();
        check_val("idle_steps", 32'(steps_seen), 32'd0);

        // Start delay swallows the first DELAY ticks
        ifc.start = 1'b1;
        cyc();
        steps_seen = 0;
        repeat (DELAY) pulse_slow();
        check_val("delay_steps", 32'(steps_seen), 32'd0);
        ifc.slow_clk = 1'b1;
        cyc();
        check_val("first_step_pulse", 32'(ifc.step_pulse), 32'd1);
        ifc.slow_clk = 1'b0;
        cyc();
        check_val("first_step_count", 32'(steps_seen), 32'd1);
        check_val("first_step_x", 32'(ifc.car_x), {2'b0, 10'd401, 10'd201, 10'd1});

        // Held-high slow clock gives a single step
        steps_seen = 0;
        ifc.slow_clk = 1'b1;
        repeat (100) cyc();
        check_val("held_high_steps", 32'(steps_seen), 32'd1);
        ifc.slow_clk = 1'b0;
        cyc();

        // start dropped in a tick cycle: no move, lane paused
        steps_seen = 0;
        ifc.slow_clk = 1'b1;
        ifc.start = 1'b0;
        cyc();
        check_val("hold_busy", 32'(ifc.busy), 32'd0);
        ifc.slow_clk = 1'b0;
        cyc();
        check_val("hold_steps", 32'(steps_seen), 32'd0);
        ifc.start = 1'b1;
        cyc();
        pulse_slow();
        check_val("resume_steps", 32'(steps_seen), 32'd1);

        // restart coincident with a tick
        ifc.slow_clk = 1'b1;
        ifc.restart = 1'b1;
        cyc();
        ifc.restart = 1'b0;
        check_val("restart_x", 32'(ifc.car_x), init_x());
        check_val("restart_step", 32'(ifc.step_pulse), 32'd0);
        check_val("restart_busy_idle", 32'(ifc.busy), 32'd0);
        cyc();
        check_val("restart_busy_wait", 32'(ifc.busy), 32'd1);
        ifc.slow_clk = 1'b0;
        cyc();

        // Wrap in both directions at the fastest speed
        ifc.dir = 1'b1;
        ifc.speed = 2'd3;
        repeat (DELAY) pulse_slow();
        ifc.slow_clk = 1'b1;
        cyc();
        check_val("left_wrap_x", 32'(ifc.car_x[9:0]), 32'd636);
        check_val("left_wrap_bits", 32'(ifc.wrap_pulse), 32'd1);
        ifc.slow_clk = 1'b0;
        cyc();
        ifc.dir = 1'b0;
        ifc.slow_clk = 1'b1;
        cyc();
        check_val("right_wrap_x", 32'(ifc.car_x[9:0]), 32'd0);
        check_val("right_wrap_bits", 32'(ifc.wrap_pulse), 32'd1);
        ifc.slow_clk = 1'b0;
        cyc();
        repeat (70) pulse_slow();

        // Asynchronous reset between clock edges
        #1 rst_n = 1'b0;
        #1;
        check_val("async_x", 32'(ifc.car_x), init_x());
        check_val("async_busy", 32'(ifc.busy), 32'd0);
        check_val("async_step", 32'(ifc.step_pulse), 32'd0);
        model_reset();
        cyc();
        rst_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 1) == 0) ifc.slow_clk = ~ifc.slow_clk;
            ifc.start   = ($urandom_range(0, 99) < 97);
            ifc.restart = ($urandom_range(0, 1999) == 0);
            ifc.dir     = 1'($urandom_range(0, 1));
            ifc.speed   = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
